// File: rtl/cpu_mem_pkg.sv
// Shared types for the Cpu-side memory port arbiter: FSM states, grant owner,
// counter widths and the saturating streak increment.
package cpu_mem_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int STREAK_W   = 4;
    localparam int TMO_W      = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } grant_owner_t;

    function automatic logic [STREAK_W-1:0] streak_sat_inc(
        input logic [STREAK_W-1:0] s,
        input logic [STREAK_W-1:0] lim
    );
        return (s >= lim) ? lim : s + STREAK_W'(1);
    endfunction

endpackage

// File: rtl/arb_grant_select.sv
// Combinational grant decision for the memory port: eligibility, data-first
// priority with a bounded data streak, and the next streak value.
module arb_grant_select
    import cpu_mem_pkg::*;
#(
    parameter int MAX_D_BURST = 4
) (
    input  logic                in_idle,
    input  logic                if_req,
    input  logic                if_ack,
    input  logic                d_req,
    input  logic                d_ack,
    input  logic [STREAK_W-1:0] streak,
    output grant_owner_t        grant,
    output logic [STREAK_W-1:0] streak_next
);

    localparam logic [STREAK_W-1:0] BURST_LIM = STREAK_W'(MAX_D_BURST);

    logic turnaround;
    logic if_elig;
    logic d_elig;

    always_comb begin
        // The completion cycle is a turnaround: no requester is re-granted while an ack is high.
        turnaround  = if_ack | d_ack;
        if_elig     = in_idle & if_req & ~turnaround;
        d_elig      = in_idle & d_req & ~turnaround;
        grant       = OWN_NONE;
        streak_next = streak;
        if (d_elig && !(if_elig && (streak == BURST_LIM))) begin
            grant       = OWN_DATA;
            streak_next = if_req ? streak_sat_inc(streak, BURST_LIM) : '0;
        end else if (if_elig) begin
            grant       = OWN_FETCH;
            streak_next = '0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between Cpu fetch and load/store, sequencing
// each access through req/ack and stalling the Cpu while anything is outstanding.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int MAX_D_BURST = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              bus_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    arb_state_t          state, state_nxt;
    logic [STREAK_W-1:0] streak, streak_nxt, streak_sel;
    logic [TMO_W-1:0]    tmo_cnt, tmo_nxt;
    grant_owner_t        grant;

    logic [ADDR_W-1:0]   mem_addr_nxt;
    logic [DATA_W-1:0]   mem_wdata_nxt;
    logic                mem_read_nxt;
    logic                mem_write_nxt;
    logic [DATA_W-1:0]   if_rdata_nxt;
    logic [DATA_W-1:0]   d_rdata_nxt;
    logic                if_ack_nxt;
    logic                d_ack_nxt;
    logic                bus_err_nxt;
    logic                finish_ok;
    logic                finish_err;

    arb_grant_select #(
        .MAX_D_BURST (MAX_D_BURST)
    ) u_grant_select (
        .in_idle     (state == IDLE),
        .if_req      (if_req),
        .if_ack      (if_ack),
        .d_req       (d_req),
        .d_ack       (d_ack),
        .streak      (streak),
        .grant       (grant),
        .streak_next (streak_sel)
    );

    assign stall = (if_req & ~if_ack) | (d_req & ~d_ack);

    always_comb begin
        state_nxt     = state;
        streak_nxt    = streak;
        tmo_nxt       = tmo_cnt;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        mem_read_nxt  = mem_read;
        mem_write_nxt = mem_write;
        if_rdata_nxt  = if_rdata;
        d_rdata_nxt   = d_rdata;
        if_ack_nxt    = 1'b0;
        d_ack_nxt     = 1'b0;
        bus_err_nxt   = 1'b0;
        finish_ok     = 1'b0;
        finish_err    = 1'b0;

        unique case (state)
            IDLE: begin
                tmo_nxt = '0;
                unique case (grant)
                    OWN_FETCH: begin
                        state_nxt     = BUSY_I;
                        streak_nxt    = streak_sel;
                        mem_addr_nxt  = if_addr;
                        mem_read_nxt  = 1'b1;
                        mem_write_nxt = 1'b0;
                    end
                    OWN_DATA: begin
                        state_nxt     = BUSY_D;
                        streak_nxt    = streak_sel;
                        mem_addr_nxt  = d_addr;
                        mem_wdata_nxt = d_wdata;
                        mem_read_nxt  = ~d_we;
                        mem_write_nxt = d_we;
                    end
                    default: ;
                endcase
            end
            BUSY_I, BUSY_D: begin
                // mem_ready takes precedence over a timeout reached in the same cycle.
                finish_ok  = mem_ready;
                finish_err = ~mem_ready & (tmo_cnt == TMO_LAST);
                if (finish_ok || finish_err) begin
                    state_nxt     = IDLE;
                    mem_read_nxt  = 1'b0;
                    mem_write_nxt = 1'b0;
                    bus_err_nxt   = finish_err;
                    if (state == BUSY_I) begin
                        if_ack_nxt   = 1'b1;
                        if_rdata_nxt = finish_ok ? mem_rdata : '0;
                    end else begin
                        d_ack_nxt = 1'b1;
                        if (mem_read) begin
                            d_rdata_nxt = finish_ok ? mem_rdata : '0;
                        end
                    end
                end else begin
                    tmo_nxt = tmo_cnt + TMO_W'(1);
                end
            end
            default: begin
                state_nxt     = IDLE;
                mem_read_nxt  = 1'b0;
                mem_write_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            streak    <= '0;
            tmo_cnt   <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            streak    <= streak_nxt;
            tmo_cnt   <= tmo_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            mem_read  <= mem_read_nxt;
            mem_write <= mem_write_nxt;
            if_rdata  <= if_rdata_nxt;
            d_rdata   <= d_rdata_nxt;
            if_ack    <= if_ack_nxt;
            d_ack     <= d_ack_nxt;
            bus_err   <= bus_err_nxt;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (MAX_D_BURST=4, TIMEOUT=8).
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        bus_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        stall;

    logic        auto_mem;
    logic        man_ready;

    int n_cmp = 0;
    int n_bad = 0;

    // Zero-wait memory answers the strobe in the same cycle; otherwise the bench drives ready.
    assign mem_ready = auto_mem ? (mem_read | mem_write) : man_ready;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .MAX_D_BURST (4),
        .TIMEOUT     (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .bus_err   (bus_err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .stall     (stall)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    initial begin
        logic exp_d [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic is_d;
        logic prev_if_ack;
        logic prev_d_ack;
        int   ng;
        int   cnt;
        bit   done;

        rst       = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_rdata = '0;
        man_ready = 1'b0;
        auto_mem  = 1'b0;

        // reset state
        #2 rst = 1'b0;
        #1;
        check_val("rst mem_read", mem_read, 0);
        check_val("rst mem_write", mem_write, 0);
        check_val("rst if_ack", if_ack, 0);
        check_val("rst d_ack", d_ack, 0);
        check_val("rst stall", stall, 0);

        // 1: fetch, memory answers in the strobe cycle
        @(negedge clk);
        rst     = 1'b1;
        if_addr = 32'h100;
        if_req  = 1'b1;
        @(negedge clk);
        check_val("t1 mem_read", mem_read, 1);
        check_val("t1 mem_addr", mem_addr, 32'h100);
        check_val("t1 mem_write", mem_write, 0);
        check_val("t1 stall", stall, 1);
        man_ready = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        check_val("t1 if_ack", if_ack, 1);
        check_val("t1 if_rdata", if_rdata, 32'hDEADBEEF);
        check_val("t1 mem_read off", mem_read, 0);
        check_val("t1 stall off", stall, 0);
        if_req    = 1'b0;
        man_ready = 1'b0;
        @(negedge clk);
        check_val("t1 if_ack pulse", if_ack, 0);
        check_val("t1 if_rdata held", if_rdata, 32'hDEADBEEF);

        // 2: store, memory ready on the third strobe cycle
        d_we    = 1'b1;
        d_addr  = 32'h200;
        d_wdata = 32'h12345678;
        d_req   = 1'b1;
        mem_rdata = 32'hBAD0BAD0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_val($sformatf("t2 mem_write c%0d", c), mem_write, 1);
            check_val($sformatf("t2 d_ack c%0d", c), d_ack, 0);
        end
        check_val("t2 mem_addr", mem_addr, 32'h200);
        check_val("t2 mem_wdata", mem_wdata, 32'h12345678);
        check_val("t2 mem_read", mem_read, 0);
        man_ready = 1'b1;
        @(negedge clk);
        check_val("t2 mem_write off", mem_write, 0);
        check_val("t2 d_ack", d_ack, 1);
        check_val("t2 d_rdata unchanged", d_rdata, 0);
        check_val("t2 bus_err", bus_err, 0);
        man_ready = 1'b0;
        d_req     = 1'b0;
        @(negedge clk);

        // 3: both sides requesting, zero-wait memory
        auto_mem    = 1'b1;
        mem_rdata   = 32'hCAFE0001;
        if_addr     = 32'h400;
        d_addr      = 32'h500;
        d_we        = 1'b0;
        if_req      = 1'b1;
        d_req       = 1'b1;
        prev_if_ack = 1'b0;
        prev_d_ack  = 1'b0;
        ng          = 0;
        for (int c = 0; c < 60 && ng < 10; c++) begin
            @(negedge clk);
            if (mem_read || mem_write) begin
                is_d = (mem_addr == 32'h500);
                check_val($sformatf("t3 grant %0d", ng), is_d, exp_d[ng]);
                check_val($sformatf("t3 ack gap %0d", ng), is_d ? prev_d_ack : prev_if_ack, 0);
                ng++;
            end
            prev_if_ack = if_ack;
            prev_d_ack  = d_ack;
        end
        check_val("t3 grant count", ng, 10);
        if_req = 1'b0;
        d_req  = 1'b0;
        repeat (3) @(negedge clk);
        auto_mem = 1'b0;
        check_val("t3 d_rdata", d_rdata, 32'hCAFE0001);
        check_val("t3 if_rdata", if_rdata, 32'hCAFE0001);

        // 4: load with no mem_ready times out after 8 strobe cycles
        d_we   = 1'b0;
        d_addr = 32'h300;
        d_req  = 1'b1;
        cnt    = 0;
        done   = 1'b0;
        for (int c = 0; c < 30 && !done; c++) begin
            @(negedge clk);
            if (mem_read) cnt++;
            else if (cnt > 0) done = 1'b1;
        end
        check_val("t4 strobe cycles", cnt, 8);
        check_val("t4 d_ack", d_ack, 1);
        check_val("t4 bus_err", bus_err, 1);
        check_val("t4 d_rdata zero", d_rdata, 0);
        d_req = 1'b0;
        @(negedge clk);
        check_val("t4 bus_err pulse", bus_err, 0);
        check_val("t4 d_ack pulse", d_ack, 0);
        check_val("t4 idle", mem_read, 0);

        // 6: mem_ready on the last allowed busy cycle wins over the timeout
        d_addr = 32'h340;
        d_req  = 1'b1;
        cnt    = 0;
        done   = 1'b0;
        for (int c = 0; c < 30 && !done; c++) begin
            @(negedge clk);
            if (mem_read) begin
                cnt++;
                if (cnt == 8) begin
                    man_ready = 1'b1;
                    mem_rdata = 32'h55AA55AA;
                end
            end else if (cnt > 0) begin
                done = 1'b1;
            end
        end
        man_ready = 1'b0;
        check_val("t6 strobe cycles", cnt, 8);
        check_val("t6 d_ack", d_ack, 1);
        check_val("t6 bus_err", bus_err, 0);
        check_val("t6 d_rdata", d_rdata, 32'h55AA55AA);
        d_req = 1'b0;
        @(negedge clk);

        // 5: asynchronous reset in the middle of a load
        d_addr = 32'h600;
        d_req  = 1'b1;
        @(negedge clk);
        check_val("t5 mem_read", mem_read, 1);
        check_val("t5 mem_addr", mem_addr, 32'h600);
        #2 rst = 1'b0;
        #1;
        check_val("t5 rst mem_read", mem_read, 0);
        check_val("t5 rst mem_addr", mem_addr, 0);
        check_val("t5 rst mem_wdata", mem_wdata, 0);
        check_val("t5 rst d_rdata", d_rdata, 0);
        check_val("t5 rst if_rdata", if_rdata, 0);
        check_val("t5 rst stall", stall, 1);
        d_req = 1'b0;
        @(negedge clk);
        rst       = 1'b1;
        man_ready = 1'b1;
        @(negedge clk);
        man_ready = 1'b0;
        check_val("t5 late ready d_ack", d_ack, 0);
        check_val("t5 late ready if_ack", if_ack, 0);
        check_val("t5 late ready mem_read", mem_read, 0);
        @(negedge clk);
        check_val("t5 still quiet", d_ack, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
